// File: rtl/cpu_mu0_param.sv
// Parametrised MU0 core on a waitrequest/readdatavalid memory bus.
// Optional opcodes LDI/AND/SHL/JLT are compiled in when CPU_MU0_EXT_OPS_EN is defined.
module cpu_mu0_param #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              running,
  output logic              illegal,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  if (DATA_W != ADDR_W + 4) begin : g_width_check
    $error("cpu_mu0_param: DATA_W must equal ADDR_W+4");
  end

  typedef enum logic [2:0] {
    FETCH_REQ, FETCH_WAIT, EXEC, EXEC_WAIT, HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'd0, OP_STO = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
    OP_JMP = 4'd4, OP_JGE = 4'd5, OP_JNE = 4'd6, OP_STP = 4'd7,
    OP_OUT = 4'd8, OP_LDI = 4'd9, OP_AND = 4'd10, OP_SHL = 4'd11,
    OP_JLT = 4'd12
  } op_e;

  state_e            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, s;
  logic [DATA_W-1:0] acc, acc_n, instr, instr_n, out_data_n;
  logic              running_n, illegal_n, out_valid_n;
  logic              bus_rd, bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  op_e               op;

  assign op     = op_e'(instr[DATA_W-1:ADDR_W]);
  assign s      = instr[ADDR_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH_REQ;
      pc        <= ADDR_W'(RESET_PC);
      acc       <= '0;
      instr     <= '0;
      running   <= 1'b1;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      acc       <= acc_n;
      instr     <= instr_n;
      running   <= running_n;
      illegal   <= illegal_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    acc_n       = acc;
    instr_n     = instr;
    running_n   = running;
    illegal_n   = illegal;
    out_valid_n = 1'b0;
    out_data_n  = out_data;
    bus_addr    = pc;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    case (state)
      FETCH_REQ: begin
        bus_rd = 1'b1;
        if (!waitrequest) state_n = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (readdatavalid) begin
          instr_n = readdata;
          state_n = EXEC;
        end
      end
      EXEC: begin
        bus_addr = s;
        case (op)
`ifdef CPU_MU0_EXT_OPS_EN
          OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
`else
          OP_LDA, OP_ADD, OP_SUB: begin
`endif
            bus_rd = 1'b1;
            if (!waitrequest) state_n = EXEC_WAIT;
          end
          OP_STO: begin
            bus_wr = 1'b1;
            if (!waitrequest) begin
              pc_n    = pc_inc;
              state_n = FETCH_REQ;
            end
          end
          OP_JMP: begin
            pc_n    = s;
            state_n = FETCH_REQ;
          end
          OP_JGE: begin
            pc_n    = acc[DATA_W-1] ? pc_inc : s;
            state_n = FETCH_REQ;
          end
          OP_JNE: begin
            pc_n    = (acc != '0) ? s : pc_inc;
            state_n = FETCH_REQ;
          end
          OP_OUT: begin
            out_valid_n = 1'b1;
            out_data_n  = acc;
            pc_n        = pc_inc;
            state_n     = FETCH_REQ;
          end
          OP_STP: begin
            running_n = 1'b0;
            state_n   = HALTED;
          end
`ifdef CPU_MU0_EXT_OPS_EN
          OP_LDI: begin
            acc_n   = DATA_W'(s);
            pc_n    = pc_inc;
            state_n = FETCH_REQ;
          end
          OP_SHL: begin
            acc_n   = acc << 1;
            pc_n    = pc_inc;
            state_n = FETCH_REQ;
          end
          OP_JLT: begin
            pc_n    = acc[DATA_W-1] ? s : pc_inc;
            state_n = FETCH_REQ;
          end
`endif
          default: begin
            illegal_n = 1'b1;
            running_n = 1'b0;
            state_n   = HALTED;
          end
        endcase
      end
      EXEC_WAIT: begin
        if (readdatavalid) begin
          case (op)
            OP_ADD:  acc_n = acc + readdata;
            OP_SUB:  acc_n = acc - readdata;
`ifdef CPU_MU0_EXT_OPS_EN
            OP_AND:  acc_n = acc & readdata;
`endif
            default: acc_n = readdata;
          endcase
          pc_n    = pc_inc;
          state_n = FETCH_REQ;
        end
      end
      HALTED: ;
      default: begin
        illegal_n = 1'b1;
        running_n = 1'b0;
        state_n   = HALTED;
      end
    endcase
  end

  // Requests are gated by rst so an abandoned transaction never reaches the bus.
  assign address   = bus_addr;
  assign read      = bus_rd & ~rst;
  assign write     = bus_wr & ~rst;
  assign writedata = acc;

endmodule

// File: tb/tb_cpu_mu0_param.sv
// Directed bench for cpu_mu0_param with a stalling, variable-latency memory model.
// Build with CPU_MU0_EXT_OPS_EN defined to exercise the extended opcodes.
module tb_cpu_mu0_param;

  logic        clk, rst;
  logic        running, illegal, read, write, waitrequest, readdatavalid, out_valid;
  logic [11:0] address;
  logic [15:0] writedata, readdata, out_data;

  cpu_mu0_param #(.ADDR_W(12), .DATA_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .running(running), .illegal(illegal),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .out_valid(out_valid), .out_data(out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [15:0] mem [4096];
  int unsigned nwait, lat, stall_cnt, pend_cnt;
  logic        p_rd, p_wr, p_wait, pend;
  logic [11:0] p_addr, pend_addr;
  logic [15:0] p_wd;

  int unsigned out_cnt, wr_cnt, rd_cnt, stab_err, halt_act;
  logic [15:0] out_last, wr_data;
  logic [11:0] wr_addr, rd_last, rd_first;
  int unsigned n_checks, n_fail;

  typedef struct {
    string       name;
    logic [15:0] prog [12];
    logic [15:0] hi;
    int unsigned nwait, lat;
    int unsigned e_out_cnt;
    logic [15:0] e_out_data;
    logic        e_illegal;
    int unsigned e_wr_cnt;
    logic [11:0] e_wr_addr;
    logic [15:0] e_wr_data;
    int unsigned e_rd_cnt;
    logic [11:0] e_rd_last;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    out_cnt = 0; wr_cnt = 0; rd_cnt = 0; stab_err = 0; halt_act = 0;
    out_last = '0; wr_data = '0; wr_addr = '0; rd_last = '0; rd_first = '0;
  endtask

  // One clock: request decision at negedge, acceptance/return bookkeeping just after posedge.
  task automatic cycle();
    @(negedge clk);
    if (p_wait && (p_rd || p_wr) && (read !== p_rd || write !== p_wr || address !== p_addr ||
        (p_wr && writedata !== p_wd)))
      stab_err++;
    if (!running && (read || write)) halt_act++;
    if ((read || write) && stall_cnt < nwait) begin
      waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      waitrequest = 1'b0;
      stall_cnt = 0;
    end
    p_rd = read; p_wr = write; p_addr = address; p_wd = writedata; p_wait = waitrequest;
    @(posedge clk);
    #1;
    readdatavalid = 1'b0;
    if (p_rd && !p_wait) begin
      rd_cnt++;
      if (rd_cnt == 1) rd_first = p_addr;
      rd_last = p_addr;
      pend = 1'b1; pend_cnt = lat; pend_addr = p_addr;
    end
    if (p_wr && !p_wait) begin
      wr_cnt++;
      mem[p_addr] = p_wd;
      wr_addr = p_addr; wr_data = p_wd;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        readdatavalid = 1'b1;
        readdata = mem[pend_addr];
        pend = 1'b0;
      end
    end
    if (out_valid) begin
      out_cnt++;
      out_last = out_data;
    end
  endtask

  task automatic do_reset(input bit clr_model);
    rst = 1'b1;
    if (clr_model) begin
      pend = 1'b0; readdatavalid = 1'b0;
    end
    p_rd = 1'b0; p_wr = 1'b0; p_wait = 1'b0; stall_cnt = 0;
    repeat (2) cycle();
    clr_counts();
    rst = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [15:0] p [12], input logic [15:0] hi,
                         input int unsigned w, input int unsigned l, input int unsigned oc,
                         input logic [15:0] od, input logic ill, input int unsigned wc,
                         input logic [11:0] wa, input logic [15:0] wd, input int unsigned rc,
                         input logic [11:0] rl);
    vec_t v;
    v.name = n; v.prog = p; v.hi = hi; v.nwait = w; v.lat = l;
    v.e_out_cnt = oc; v.e_out_data = od; v.e_illegal = ill;
    v.e_wr_cnt = wc; v.e_wr_addr = wa; v.e_wr_data = wd;
    v.e_rd_cnt = rc; v.e_rd_last = rl;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] p [12];
    n_checks = 0; n_fail = 0;
    rst = 1'b1; waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
    nwait = 0; lat = 1; stall_cnt = 0; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
    p_rd = 1'b0; p_wr = 1'b0; p_wait = 1'b0; p_addr = '0; p_wd = '0;
    clr_counts();
    for (int unsigned a = 0; a < 4096; a++) mem[a] = '0;

    // Reset state, sampled while rst is held.
    repeat (2) @(negedge clk);
    check("rst_running", running, 1);
    check("rst_illegal", illegal, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_acc", writedata, 0);
    check("rst_address", address, 0);

    p = '{16'h0005, 16'h2006, 16'h8000, 16'h7000, 16'h0, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    add_vec("lda_add_out",   p, 16'h0, 0, 1, 1, 16'h0004, 0, 0, 0, 16'h0, 6, 3);
    add_vec("lda_add_stall", p, 16'h0, 3, 5, 1, 16'h0004, 0, 0, 0, 16'h0, 6, 3);
    p = '{16'h0004, 16'h1005, 16'h7000, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    add_vec("lda_sto",       p, 16'h0, 0, 1, 0, 16'h0000, 0, 1, 5, 16'h1234, 4, 2);
    p = '{16'h0005, 16'h5009, 16'h8000, 16'h7000, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 16'hD000, 16'h0, 16'h0};
    add_vec("jge_neg_fall",  p, 16'h0, 0, 1, 1, 16'h8000, 0, 0, 0, 16'h0, 5, 3);
    p = '{16'h0005, 16'h6009, 16'hD000, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h7000, 16'h0};
    add_vec("jne_take",      p, 16'h0, 0, 1, 1, 16'h8000, 0, 0, 0, 16'h0, 5, 10);
    p = '{16'h0007, 16'h6009, 16'h8000, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hD000, 16'h0, 16'h0};
    add_vec("jne_zero_fall", p, 16'h0, 0, 1, 1, 16'h0000, 0, 0, 0, 16'h0, 5, 3);
    p = '{16'h4009, 16'hD000, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h3005, 16'h8000, 16'h7000};
    add_vec("jmp_sub_wrap",  p, 16'h0, 1, 2, 1, 16'hFFFF, 0, 0, 0, 16'h0, 5, 11);
    p = '{16'h6003, 16'h0005, 16'h4FFF, 16'h7000, 16'h0, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    add_vec("pc_wrap",       p, 16'h8000, 0, 1, 1, 16'h0007, 0, 0, 0, 16'h0, 7, 3);
    p = '{16'hD000, 16'h8000, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    add_vec("illegal_d000",  p, 16'h0, 0, 1, 0, 16'h0000, 1, 0, 0, 16'h0, 1, 0);
    p = '{16'h9123, 16'h8000, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
`ifdef CPU_MU0_EXT_OPS_EN
    add_vec("ldi_9123",      p, 16'h0, 0, 1, 1, 16'h0123, 0, 0, 0, 16'h0, 3, 2);
`else
    add_vec("illegal_9000",  p, 16'h0, 0, 1, 0, 16'h0000, 1, 0, 0, 16'h0, 1, 0);
`endif

    foreach (vecs[i]) begin
      for (int unsigned a = 0; a < 4096; a++) mem[a] = '0;
      for (int unsigned a = 0; a < 12; a++) mem[a] = vecs[i].prog[a];
      mem[4095] = vecs[i].hi;
      nwait = vecs[i].nwait; lat = vecs[i].lat;
      do_reset(1'b1);
      for (int c = 0; c < 800 && running; c++) cycle();
      check($sformatf("%s_halted", vecs[i].name), running, 0);
      repeat (6) cycle();
      check($sformatf("%s_illegal", vecs[i].name), illegal, vecs[i].e_illegal);
      check($sformatf("%s_out_cnt", vecs[i].name), out_cnt, vecs[i].e_out_cnt);
      check($sformatf("%s_out_data", vecs[i].name), out_data, vecs[i].e_out_data);
      check($sformatf("%s_out_pulse_data", vecs[i].name), out_last, vecs[i].e_out_data);
      check($sformatf("%s_wr_cnt", vecs[i].name), wr_cnt, vecs[i].e_wr_cnt);
      check($sformatf("%s_wr_addr", vecs[i].name), wr_addr, vecs[i].e_wr_addr);
      check($sformatf("%s_wr_data", vecs[i].name), wr_data, vecs[i].e_wr_data);
      check($sformatf("%s_rd_cnt", vecs[i].name), rd_cnt, vecs[i].e_rd_cnt);
      check($sformatf("%s_rd_last", vecs[i].name), rd_last, vecs[i].e_rd_last);
      check($sformatf("%s_stable", vecs[i].name), stab_err, 0);
      check($sformatf("%s_halt_quiet", vecs[i].name), halt_act, 0);
    end

    // Reset while an operand read is outstanding; its late return lands during a stalled fetch.
    for (int unsigned a = 0; a < 4096; a++) mem[a] = '0;
    mem[0] = 16'h0005; mem[5] = 16'hAAAA;
    nwait = 0; lat = 8;
    do_reset(1'b1);
    for (int c = 0; c < 50 && rd_cnt < 2; c++) cycle();
    check("stale_operand_read_accepted", rd_cnt, 2);
    cycle();
    rst = 1'b1;
    #1;
    check("stale_rst_read_gated", read, 0);
    check("stale_rst_write_gated", write, 0);
    check("stale_rst_acc", writedata, 0);
    mem[0] = 16'h8000; mem[1] = 16'h7000; mem[5] = 16'hBEEF;
    nwait = 12;
    do_reset(1'b0);
    for (int c = 0; c < 300 && running; c++) cycle();
    check("stale_halted", running, 0);
    check("stale_first_fetch", rd_first, 0);
    check("stale_rd_cnt", rd_cnt, 2);
    check("stale_out_cnt", out_cnt, 1);
    check("stale_out_data", out_data, 0);
    check("stale_illegal", illegal, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
